// File: rtl/cpu_out_queue_if.sv
// Dequeue-side valid/ready handshake of the cpu output queue.
// The master drives the head word and the slave accepts it.
interface cpu_out_queue_if #(
   parameter int DATA_W = 64
);
   logic              deq_valid;
   logic [DATA_W-1:0] deq_data;
   logic              deq_ready;

   modport master (output deq_valid, output deq_data, input deq_ready);
   modport slave  (input deq_valid, input deq_data, output deq_ready);
endinterface

// File: rtl/cpu_out_queue.sv
// Show-ahead FIFO capturing cpu output words, with drop accounting and a
// drained flag once the cpu has halted and every word has been consumed.
module cpu_out_queue #(
   parameter int DEPTH  = 8,
   parameter int DATA_W = 64,
   parameter int CNT_W  = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     out_signal,
   input  logic [DATA_W-1:0]        out_data,
   input  logic                     halt,
   cpu_out_queue_if.master          deq,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     overflow,
   output logic [CNT_W-1:0]         drop_count,
   output logic                     drained
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              overflow_q, overflow_d;
   logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
   logic              halt_seen_q, halt_seen_d;
   logic              is_full, pop, push_acc, push_drop;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   always_comb begin
      is_full   = (count_q == CW'(DEPTH));
      pop       = (count_q != '0) && deq.deq_ready;
      // A full queue still accepts a word when the head leaves in the same cycle.
      push_acc  = out_signal && (!is_full || pop);
      push_drop = out_signal && is_full && !pop;

      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      drop_cnt_d  = drop_cnt_q;
      halt_seen_d = halt_seen_q | halt;

      if (push_acc) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)      rd_ptr_d = rd_ptr_q + AW'(1);

      if (push_acc && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push_acc) count_d = count_q - CW'(1);

      if (push_drop) begin
         overflow_d = 1'b1;
         drop_cnt_d = sat_inc(drop_cnt_q);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         drop_cnt_q  <= '0;
         halt_seen_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         drop_cnt_q  <= drop_cnt_d;
         halt_seen_q <= halt_seen_d;
      end
   end

   // Storage carries no reset; only occupancy decides what is meaningful.
   always_ff @(posedge clk) begin
      if (push_acc) mem_q[wr_ptr_q] <= out_data;
   end

   assign deq.deq_valid = (count_q != '0);
   assign deq.deq_data  = mem_q[rd_ptr_q];
   assign count         = count_q;
   assign full          = is_full;
   assign overflow      = overflow_q;
   assign drop_count    = drop_cnt_q;
   assign drained       = halt_seen_q && (count_q == '0);
endmodule
